pipe_em_reg: RTL and testbench

- EXE/MEM pipeline register sitting directly downstream of the EXE stage.
- Captures every EXE-stage output bundle each cycle and presents it to the MEM stage.
- Supports MEM-side stall (hold), exception flush (bubble) and EXE-side invalid (bubble).
- Provides registered-stage forwarding information to the hazard unit and a wrapping count of instructions entering MEM.

---
 rtl/pipe_em_reg_if.sv | 59 +++++
 rtl/pipe_em_reg.sv | 139 +++++++++++++
 tb/tb_pipe_em_reg.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_em_reg_if.sv
// EXE/MEM boundary bundle: EXE-side fields and controls flow into the
// pipeline register, MEM-side registered copies and hazard info flow out.
interface pipe_em_reg_if;
   // Stage controls
   logic        stall;
   logic        flush;
   logic        Evalid;

   // EXE-side bundle
   logic [31:0] Ealu, Ea, Eb, Ecounter, Ecp0, Ehi, Elo;
   logic [31:0] Emuler_hi, Emuler_lo, Epc4, Eq, Er;
   logic [1:0]  Ecuttersource, Ehisource, Elosource;
   logic [2:0]  Erfsource;
   logic [4:0]  Ern;
   logic        EisGoto, Esign, Ew_dm, Ew_hi, Ew_lo, Ew_rf;

   // MEM-side registered bundle
   logic [31:0] Malu, Ma, Mb, Mcounter, Mcp0, Mhi, Mlo;
   logic [31:0] Mmuler_hi, Mmuler_lo, Mpc4, Mq, Mr;
   logic [1:0]  Mcuttersource, Mhisource, Mlosource;
   logic [2:0]  Mrfsource;
   logic [4:0]  Mrn;
   logic        MisGoto, Msign, Mw_dm, Mw_hi, Mw_lo, Mw_rf;
   logic        Mvalid;

   // Hazard-unit view and instruction count
   logic        fwd_en;
   logic [31:0] fwd_data;
   logic        load_pending;
   logic [31:0] retired_cnt;

   // EXE stage / environment side
   modport master (
      output stall, flush, Evalid,
      output Ealu, Ea, Eb, Ecounter, Ecp0, Ehi, Elo,
      output Emuler_hi, Emuler_lo, Epc4, Eq, Er,
      output Ecuttersource, Ehisource, Elosource, Erfsource, Ern,
      output EisGoto, Esign, Ew_dm, Ew_hi, Ew_lo, Ew_rf,
      input  Malu, Ma, Mb, Mcounter, Mcp0, Mhi, Mlo,
      input  Mmuler_hi, Mmuler_lo, Mpc4, Mq, Mr,
      input  Mcuttersource, Mhisource, Mlosource, Mrfsource, Mrn,
      input  MisGoto, Msign, Mw_dm, Mw_hi, Mw_lo, Mw_rf, Mvalid,
      input  fwd_en, fwd_data, load_pending, retired_cnt
   );

   // Pipeline register side
   modport slave (
      input  stall, flush, Evalid,
      input  Ealu, Ea, Eb, Ecounter, Ecp0, Ehi, Elo,
      input  Emuler_hi, Emuler_lo, Epc4, Eq, Er,
      input  Ecuttersource, Ehisource, Elosource, Erfsource, Ern,
      input  EisGoto, Esign, Ew_dm, Ew_hi, Ew_lo, Ew_rf,
      output Malu, Ma, Mb, Mcounter, Mcp0, Mhi, Mlo,
      output Mmuler_hi, Mmuler_lo, Mpc4, Mq, Mr,
      output Mcuttersource, Mhisource, Mlosource, Mrfsource, Mrn,
      output MisGoto, Msign, Mw_dm, Mw_hi, Mw_lo, Mw_rf, Mvalid,
      output fwd_en, fwd_data, load_pending, retired_cnt
   );
endinterface

// File: rtl/pipe_em_reg.sv
// EXE/MEM pipeline register. Captures the EXE bundle every edge, with
// flush > stall > load priority; an invalid EXE slot becomes a bubble.
// Also derives forwarding info for the hazard unit and counts valid
// instructions entering MEM.
// Handshake: there is no valid/ready pair here; Evalid qualifies the EXE
// bundle on each edge, and stall (MEM busy) freezes the whole stage, so an
// EXE instruction is accepted only on an edge with flush=0 and stall=0.
module pipe_em_reg #(
   parameter logic [2:0] RFSRC_DMEM = 3'd1
) (
   input  logic     clk,
   input  logic     resetn,
   pipe_em_reg_if.slave bus
);

   typedef struct packed {
      logic [31:0] alu, a, b, counter, cp0, hi, lo;
      logic [31:0] muler_hi, muler_lo, pc4, q, r;
      logic [1:0]  cuttersource, hisource, losource;
      logic [2:0]  rfsource;
      logic [4:0]  rn;
      logic        isgoto, sign, w_dm, w_hi, w_lo, w_rf;
   } em_bundle_t;

   em_bundle_t  e_in;
   em_bundle_t  m_q;
   logic        m_valid;
   logic [31:0] retired_cnt;
   logic        load_en;
   logic        m_writes_rf;

   // An instruction enters MEM only when neither flushed nor stalled
   assign load_en = !bus.flush && !bus.stall && bus.Evalid;

   // Gather the EXE-side fields into one bundle
   always_comb begin
      e_in              = '0;
      e_in.alu          = bus.Ealu;
      e_in.a            = bus.Ea;
      e_in.b            = bus.Eb;
      e_in.counter      = bus.Ecounter;
      e_in.cp0          = bus.Ecp0;
      e_in.hi           = bus.Ehi;
      e_in.lo           = bus.Elo;
      e_in.muler_hi     = bus.Emuler_hi;
      e_in.muler_lo     = bus.Emuler_lo;
      e_in.pc4          = bus.Epc4;
      e_in.q            = bus.Eq;
      e_in.r            = bus.Er;
      e_in.cuttersource = bus.Ecuttersource;
      e_in.hisource     = bus.Ehisource;
      e_in.losource     = bus.Elosource;
      e_in.rfsource     = bus.Erfsource;
      e_in.rn           = bus.Ern;
      e_in.isgoto       = bus.EisGoto;
      e_in.sign         = bus.Esign;
      e_in.w_dm         = bus.Ew_dm;
      e_in.w_hi         = bus.Ew_hi;
      e_in.w_lo         = bus.Ew_lo;
      e_in.w_rf         = bus.Ew_rf;
   end

   // Stage register: flush or invalid EXE gives an all-zero bubble, stall holds
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_q     <= '0;
         m_valid <= 1'b0;
      end else if (bus.flush) begin
         m_q     <= '0;
         m_valid <= 1'b0;
      end else if (bus.stall) begin
         m_q     <= m_q;
         m_valid <= m_valid;
      end else if (bus.Evalid) begin
         m_q     <= e_in;
         m_valid <= 1'b1;
      end else begin
         m_q     <= '0;
         m_valid <= 1'b0;
      end
   end

   // Wrapping count of valid instructions loaded into MEM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         retired_cnt <= 32'd0;
      end else if (load_en) begin
         retired_cnt <= retired_cnt + 32'd1;
      end
   end

   // A live register write that could be seen by younger instructions
   assign m_writes_rf = m_valid && m_q.w_rf && (m_q.rn != 5'd0);

   // Forwarding value chosen by write-back source; loads have nothing yet
   always_comb begin
      bus.fwd_data = 32'd0;
      case (m_q.rfsource)
         3'd0:    bus.fwd_data = m_q.alu;
         3'd2:    bus.fwd_data = m_q.hi;
         3'd3:    bus.fwd_data = m_q.lo;
         3'd4:    bus.fwd_data = m_q.muler_lo;
         3'd5:    bus.fwd_data = m_q.cp0;
         3'd6:    bus.fwd_data = m_q.q;
         3'd7:    bus.fwd_data = m_q.r;
         default: bus.fwd_data = 32'd0;
      endcase
   end

   assign bus.fwd_en       = m_writes_rf && (m_q.rfsource != RFSRC_DMEM);
   assign bus.load_pending = m_writes_rf && (m_q.rfsource == RFSRC_DMEM);
   assign bus.retired_cnt  = retired_cnt;
   assign bus.Mvalid       = m_valid;

   assign bus.Malu          = m_q.alu;
   assign bus.Ma            = m_q.a;
   assign bus.Mb            = m_q.b;
   assign bus.Mcounter      = m_q.counter;
   assign bus.Mcp0          = m_q.cp0;
   assign bus.Mhi           = m_q.hi;
   assign bus.Mlo           = m_q.lo;
   assign bus.Mmuler_hi     = m_q.muler_hi;
   assign bus.Mmuler_lo     = m_q.muler_lo;
   assign bus.Mpc4          = m_q.pc4;
   assign bus.Mq            = m_q.q;
   assign bus.Mr            = m_q.r;
   assign bus.Mcuttersource = m_q.cuttersource;
   assign bus.Mhisource     = m_q.hisource;
   assign bus.Mlosource     = m_q.losource;
   assign bus.Mrfsource     = m_q.rfsource;
   assign bus.Mrn           = m_q.rn;
   assign bus.MisGoto       = m_q.isgoto;
   assign bus.Msign         = m_q.sign;
   assign bus.Mw_dm         = m_q.w_dm;
   assign bus.Mw_hi         = m_q.w_hi;
   assign bus.Mw_lo         = m_q.w_lo;
   assign bus.Mw_rf         = m_q.w_rf;

endmodule

// File: tb/tb_pipe_em_reg.sv
// Bench for pipe_em_reg: reset, a stimulus table, directed multi-cycle
// sequences (stall hold, flush priority, counter wrap, async reset) and a
// randomized run against a reference model of the stage.
module tb_pipe_em_reg;

   typedef struct packed {
      logic [31:0] alu, a, b, counter, cp0, hi, lo;
      logic [31:0] muler_hi, muler_lo, pc4, q, r;
      logic [1:0]  cuttersource, hisource, losource;
      logic [2:0]  rfsource;
      logic [4:0]  rn;
      logic        isgoto, sign, w_dm, w_hi, w_lo, w_rf;
   } bundle_t;

   localparam int W = $bits(bundle_t);

   typedef struct {
      bundle_t     e;
      logic        v, st, fl;
      logic        x_valid, x_en, x_lp;
      logic [31:0] x_data;
   } vec_t;

   logic clk;
   logic resetn;
   pipe_em_reg_if bus ();

   pipe_em_reg dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   bundle_t     m_exp;
   logic        v_exp;
   logic [31:0] cnt_exp;
   logic [W-1:0] exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.alu = $urandom; b.a = $urandom; b.b = $urandom; b.counter = $urandom;
      b.cp0 = $urandom; b.hi = $urandom; b.lo = $urandom;
      b.muler_hi = $urandom; b.muler_lo = $urandom; b.pc4 = $urandom;
      b.q = $urandom; b.r = $urandom;
      b.cuttersource = 2'($urandom_range(0, 3));
      b.hisource     = 2'($urandom_range(0, 3));
      b.losource     = 2'($urandom_range(0, 3));
      b.rfsource     = 3'($urandom_range(0, 7));
      b.rn           = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b.isgoto = 1'($urandom); b.sign = 1'($urandom); b.w_dm = 1'($urandom);
      b.w_hi = 1'($urandom); b.w_lo = 1'($urandom); b.w_rf = 1'($urandom);
      return b;
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input bundle_t e, input logic v, input logic st, input logic fl);
      bus.Ealu = e.alu; bus.Ea = e.a; bus.Eb = e.b; bus.Ecounter = e.counter;
      bus.Ecp0 = e.cp0; bus.Ehi = e.hi; bus.Elo = e.lo;
      bus.Emuler_hi = e.muler_hi; bus.Emuler_lo = e.muler_lo; bus.Epc4 = e.pc4;
      bus.Eq = e.q; bus.Er = e.r;
      bus.Ecuttersource = e.cuttersource; bus.Ehisource = e.hisource;
      bus.Elosource = e.losource; bus.Erfsource = e.rfsource; bus.Ern = e.rn;
      bus.EisGoto = e.isgoto; bus.Esign = e.sign; bus.Ew_dm = e.w_dm;
      bus.Ew_hi = e.w_hi; bus.Ew_lo = e.w_lo; bus.Ew_rf = e.w_rf;
      bus.Evalid = v; bus.stall = st; bus.flush = fl;
   endtask

   function automatic bundle_t get_m();
      bundle_t r;
      r.alu = bus.Malu; r.a = bus.Ma; r.b = bus.Mb; r.counter = bus.Mcounter;
      r.cp0 = bus.Mcp0; r.hi = bus.Mhi; r.lo = bus.Mlo;
      r.muler_hi = bus.Mmuler_hi; r.muler_lo = bus.Mmuler_lo; r.pc4 = bus.Mpc4;
      r.q = bus.Mq; r.r = bus.Mr;
      r.cuttersource = bus.Mcuttersource; r.hisource = bus.Mhisource;
      r.losource = bus.Mlosource; r.rfsource = bus.Mrfsource; r.rn = bus.Mrn;
      r.isgoto = bus.MisGoto; r.sign = bus.Msign; r.w_dm = bus.Mw_dm;
      r.w_hi = bus.Mw_hi; r.w_lo = bus.Mw_lo; r.w_rf = bus.Mw_rf;
      return r;
   endfunction

   // ---------------- reference model ----------------
   // The MEM stage holds the last accepted instruction, or nothing.
   task automatic model_reset();
      m_exp   = '0;
      v_exp   = 1'b0;
      cnt_exp = 32'd0;
      exp_q.push_back(m_exp);
   endtask

   task automatic model_edge(input bundle_t e, input logic v, input logic st, input logic fl);
      if (fl || (!st && !v)) begin
         m_exp = '0;
         v_exp = 1'b0;
      end else if (!st) begin
         m_exp   = e;
         v_exp   = 1'b1;
         cnt_exp = cnt_exp + 32'd1;
      end
      exp_q.push_back(m_exp);
   endtask

   // Hazard view computed straight from the source table
   task automatic fwd_model(input bundle_t m, input logic v, output logic en,
                            output logic [31:0] d, output logic lp);
      logic [31:0] src [8];
      logic writes;
      src    = '{m.alu, 32'd0, m.hi, m.lo, m.muler_lo, m.cp0, m.q, m.r};
      d      = src[m.rfsource];
      writes = v && m.w_rf && (m.rn != 5'd0);
      en     = writes && (m.rfsource != 3'd1);
      lp     = writes && (m.rfsource == 3'd1);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name);
      bundle_t     act, exp;
      logic        en, lp;
      logic [31:0] d;
      act = get_m();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s.scoreboard: got empty queue expected one entry", name);
         exp = m_exp;
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.bundle: got %h expected %h", name, act, exp);
         end
      end
      fwd_model(exp, v_exp, en, d, lp);
      chk32({name, ".Mvalid"},       32'(bus.Mvalid),       32'(v_exp));
      chk32({name, ".retired_cnt"},  bus.retired_cnt,       cnt_exp);
      chk32({name, ".fwd_en"},       32'(bus.fwd_en),       32'(en));
      chk32({name, ".fwd_data"},     bus.fwd_data,          d);
      chk32({name, ".load_pending"}, 32'(bus.load_pending), 32'(lp));
      n_checks++;
      if (!bus.Mvalid && (bus.Mw_rf || bus.Mw_dm || bus.Mw_hi || bus.Mw_lo || bus.MisGoto)) begin
         n_errors++;
         $display("FAIL %s.bubble_flags: got write flags set expected none while Mvalid=0", name);
      end
   endtask

   // One clock: drive at negedge, model on posedge, check at next negedge
   task automatic step(input string name, input bundle_t e, input logic v,
                       input logic st, input logic fl);
      drive(e, v, st, fl);
      @(posedge clk);
      model_edge(e, v, st, fl);
      @(negedge clk);
      check_all(name);
   endtask

   // ---------------- stimulus ----------------
   vec_t    tbl [10];
   bundle_t z, b;

   task automatic set_vec(input int i, input bundle_t e, input logic v, input logic st,
                          input logic fl, input logic xv, input logic xen,
                          input logic xlp, input logic [31:0] xd);
      tbl[i].e = e; tbl[i].v = v; tbl[i].st = st; tbl[i].fl = fl;
      tbl[i].x_valid = xv; tbl[i].x_en = xen; tbl[i].x_lp = xlp; tbl[i].x_data = xd;
   endtask

   initial begin
      z = '0;

      // Table: forwarding source selection and bubble cases
      b = z; b.rfsource = 3'd1; b.rn = 5'd9; b.w_rf = 1'b1; b.alu = 32'h77;
      set_vec(0, b, 1, 0, 0, 1, 0, 1, 32'd0);
      b = z; b.rfsource = 3'd2; b.rn = 5'd3; b.w_rf = 1'b1; b.hi = 32'hDEAD_BEEF;
      set_vec(1, b, 1, 0, 0, 1, 1, 0, 32'hDEAD_BEEF);
      b = z; b.rfsource = 3'd0; b.rn = 5'd0; b.w_rf = 1'b1; b.alu = 32'h5;
      set_vec(2, b, 1, 0, 0, 1, 0, 0, 32'h5);
      b = z; b.rfsource = 3'd3; b.rn = 5'd4; b.w_rf = 1'b1; b.lo = 32'h1111;
      set_vec(3, b, 1, 0, 0, 1, 1, 0, 32'h1111);
      b = z; b.rfsource = 3'd4; b.rn = 5'd5; b.w_rf = 1'b1; b.muler_lo = 32'h2222; b.muler_hi = 32'h9;
      set_vec(4, b, 1, 0, 0, 1, 1, 0, 32'h2222);
      b = z; b.rfsource = 3'd5; b.rn = 5'd6; b.w_rf = 1'b1; b.cp0 = 32'h3333;
      set_vec(5, b, 1, 0, 0, 1, 1, 0, 32'h3333);
      b = z; b.rfsource = 3'd6; b.rn = 5'd7; b.w_rf = 1'b1; b.q = 32'h4444;
      set_vec(6, b, 1, 0, 0, 1, 1, 0, 32'h4444);
      b = z; b.rfsource = 3'd7; b.rn = 5'd31; b.w_rf = 1'b0; b.r = 32'h5555;
      set_vec(7, b, 1, 0, 0, 1, 0, 0, 32'h5555);
      b = z; b.rfsource = 3'd7; b.rn = 5'd2; b.w_rf = 1'b1; b.r = 32'h6666; b.w_dm = 1'b1;
      set_vec(8, b, 0, 0, 0, 0, 0, 0, 32'd0);
      b = z; b.rfsource = 3'd0; b.rn = 5'd2; b.w_rf = 1'b1; b.alu = 32'h7777; b.isgoto = 1'b1;
      set_vec(9, b, 1, 0, 1, 0, 0, 0, 32'd0);

      // Reset with random EXE activity
      resetn = 1'b0;
      drive(rand_bundle(), 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      model_reset();
      check_all("reset");

      // First load after release
      resetn = 1'b1;
      b = rand_bundle(); b.alu = 32'h1234_5678; b.rn = 5'd8; b.w_rf = 1'b1; b.rfsource = 3'd0;
      step("first_load", b, 1'b1, 1'b0, 1'b0);
      chk32("first_load.Malu",     bus.Malu,          32'h1234_5678);
      chk32("first_load.fwd_en",   32'(bus.fwd_en),   32'd1);
      chk32("first_load.fwd_data", bus.fwd_data,      32'h1234_5678);
      chk32("first_load.cnt",      bus.retired_cnt,   32'd1);

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         step($sformatf("vec%0d", i), tbl[i].e, tbl[i].v, tbl[i].st, tbl[i].fl);
         chk32($sformatf("vec%0d.Mvalid", i), 32'(bus.Mvalid), 32'(tbl[i].x_valid));
         chk32($sformatf("vec%0d.fwd_en", i), 32'(bus.fwd_en), 32'(tbl[i].x_en));
         chk32($sformatf("vec%0d.load_pending", i), 32'(bus.load_pending), 32'(tbl[i].x_lp));
         chk32($sformatf("vec%0d.fwd_data", i), bus.fwd_data, tbl[i].x_data);
      end

      // Stall hold across three cycles
      b = z; b.alu = 32'hA; b.rn = 5'd10; b.w_rf = 1'b1;
      step("stall_pre", b, 1'b1, 1'b0, 1'b0);
      begin
         logic [31:0] cnt_before;
         cnt_before = bus.retired_cnt;
         b.alu = 32'hB;
         for (int k = 0; k < 3; k++) begin
            step("stall_hold", b, 1'b1, 1'b1, 1'b0);
            chk32("stall_hold.Malu", bus.Malu, 32'hA);
            chk32("stall_hold.fwd_data", bus.fwd_data, 32'hA);
            chk32("stall_hold.cnt", bus.retired_cnt, cnt_before);
         end
         step("stall_release", b, 1'b1, 1'b0, 1'b0);
         chk32("stall_release.Malu", bus.Malu, 32'hB);
         chk32("stall_release.cnt", bus.retired_cnt, cnt_before + 32'd1);
      end

      // Flush wins over stall; invalid EXE gives the same bubble
      b = rand_bundle(); b.w_dm = 1'b1;
      step("flush_pre", b, 1'b1, 1'b0, 1'b0);
      step("flush_stall", b, 1'b1, 1'b1, 1'b1);
      chk32("flush_stall.Mw_dm", 32'(bus.Mw_dm), 32'd0);
      chk32("flush_stall.Mvalid", 32'(bus.Mvalid), 32'd0);
      chk32("flush_stall.Malu", bus.Malu, 32'd0);
      step("bubble_pre", b, 1'b1, 1'b0, 1'b0);
      step("evalid_low", b, 1'b0, 1'b0, 1'b0);
      chk32("evalid_low.Mw_dm", 32'(bus.Mw_dm), 32'd0);
      chk32("evalid_low.Mvalid", 32'(bus.Mvalid), 32'd0);

      // Counter wrap through a backdoor preload
      force dut.retired_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retired_cnt;
      cnt_exp = 32'hFFFF_FFFF;
      step("wrap", rand_bundle(), 1'b1, 1'b0, 1'b0);
      chk32("wrap.cnt", bus.retired_cnt, 32'd0);
      step("wrap_flush", rand_bundle(), 1'b1, 1'b0, 1'b1);
      chk32("wrap_flush.cnt", bus.retired_cnt, 32'd0);
      step("wrap_stall", rand_bundle(), 1'b1, 1'b1, 1'b0);
      chk32("wrap_stall.cnt", bus.retired_cnt, 32'd0);

      // Asynchronous reset while stalled with a valid instruction
      b = rand_bundle(); b.w_rf = 1'b1; b.rn = 5'd12; b.rfsource = 3'd0;
      step("async_pre", b, 1'b1, 1'b0, 1'b0);
      step("async_stall", b, 1'b1, 1'b1, 1'b0);
      #1 resetn = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      resetn = 1'b1;

      // Randomized run against the model
      for (int n = 0; n < 400; n++) begin
         logic v, st, fl;
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 7) == 0);
         step("random", rand_bundle(), v, st, fl);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
